// File: rtl/alu_arbiter_pkg.sv
// Shared types and opcode constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational n-bit ALU; result is zero-extended to n+1 bits and forced to 0 when en is low.
module ALU
  import alu_arbiter_pkg::*;
#(
  parameter int n = 8
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [2:0]   sel,
  input  logic         en,
  output logic [n:0]   Q
);

  logic [n-1:0] w_res;

  always_comb begin
    w_res = '0;
    if (en) begin
      case (sel)
        OP_ADD:  w_res = A + B;
        OP_SUB:  w_res = A - B;
        OP_MUL:  w_res = A * B;
        // Divide-by-zero returns all ones so the result is never X.
        OP_DIV:  w_res = (B == '0) ? '1 : A / B;
        OP_AND:  w_res = A & B;
        OP_OR:   w_res = A | B;
        OP_XOR:  w_res = A ^ B;
        OP_NOR:  w_res = ~(A | B);
        default: w_res = '0;
      endcase
    end
    Q = {1'b0, w_res};
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, IDLE/EXEC/RESP sequencing.
// Optional feature macro: ALU_ARBITER_DIVZERO_EN (divide-by-zero yields Q=0 and rsp_err=1).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int n = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][n-1:0]   req_A,
  input  logic [1:0][n-1:0]   req_B,
  input  logic [1:0][2:0]     req_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [n:0]          rsp_Q,
  output logic                rsp_err
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_last;
  logic [n-1:0] r_A;
  logic [n-1:0] r_B;
  logic [2:0]   r_sel;
  logic         r_id;
  logic [n:0]   r_rsp_Q;
  logic         r_rsp_err;

  logic         w_any;
  logic         w_grant;
  logic         w_accept;
  logic         w_en;
  logic         w_divzero;
  logic [1:0]   w_ready;
  logic [n:0]   w_alu_Q;

  // The pointer holds the last winner; on contention the other requester wins.
  always_comb begin
    w_any   = |req_valid;
    w_grant = (&req_valid) ? ~r_last : req_valid[1];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 2'b00;
    w_en        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_ready     = w_grant ? 2'b10 : 2'b01;
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_en        = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef ALU_ARBITER_DIVZERO_EN
  assign w_divzero = (r_sel == OP_DIV) && (r_B == '0);
`else
  assign w_divzero = 1'b0;
`endif

  ALU #(.n(n)) u_alu (
    .A   (r_A),
    .B   (r_B),
    .sel (r_sel),
    .en  (w_en),
    .Q   (w_alu_Q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last    <= 1'b1;
      r_A       <= '0;
      r_B       <= '0;
      r_sel     <= '0;
      r_id      <= 1'b0;
      r_rsp_Q   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_A    <= req_A[w_grant];
        r_B    <= req_B[w_grant];
        r_sel  <= req_sel[w_grant];
        r_id   <= w_grant;
        r_last <= w_grant;
      end
      if (r_state == EXEC) begin
        r_rsp_Q   <= w_divzero ? '0 : w_alu_Q;
        r_rsp_err <= w_divzero;
      end
    end
  end

  // r_id only changes on acceptance in IDLE, so it is stable throughout RESP.
  assign req_ready = w_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_Q     = r_rsp_Q;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; define ALU_ARBITER_DIVZERO_EN to cover divide-by-zero.
module tb_alu_arbiter;

  localparam int N = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][N-1:0]   req_A;
  logic [1:0][N-1:0]   req_B;
  logic [1:0][2:0]     req_sel;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [N:0]          rsp_Q;
  logic                rsp_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_A     (req_A),
    .req_B     (req_B),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_Q     (rsp_Q),
    .rsp_err   (rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_A     = '0;
    req_B     = '0;
    req_sel   = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    tests++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl: valid/id/err got %b expected 000", {rsp_valid, rsp_id, rsp_err});
    end
    tests++;
    if (rsp_Q !== 9'h000) begin
      fails++;
      $display("FAIL reset_q: got %h expected 000", rsp_Q);
    end
    tests++;
    if (req_ready !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 00", req_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    req_A[0] = 8'd200; req_B[0] = 8'd100; req_sel[0] = 3'b000;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL add_ready: got %b expected 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_latency1: rsp_valid got %b expected 0", rsp_valid);
    end
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_Q !== 9'h02C || rsp_id !== 1'b0) begin
      fails++;
      $display("FAIL add_result: valid=%b Q=%h id=%b expected 1 02C 0", rsp_valid, rsp_Q, rsp_id);
    end
    tick();
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_release: rsp_valid got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_contention();
    logic [N:0] q [2];
    logic       idv [2];
    logic [1:0] acc;
    int         nrsp;
    nrsp = 0;
    q[0] = '1; q[1] = '1; idv[0] = 1'bx; idv[1] = 1'bx;
    rst_n = 1'b0;
    req_A[0] = 8'd5; req_B[0] = 8'd3; req_sel[0] = 3'b001;
    req_A[1] = 8'd3; req_B[1] = 8'd5; req_sel[1] = 3'b001;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 30 && nrsp < 2; c++) begin
      tests++;
      if (req_ready === 2'b11) begin
        fails++;
        $display("FAIL cont_onehot: req_ready got %b expected not 11", req_ready);
      end
      if (rsp_valid) begin
        q[nrsp]   = rsp_Q;
        idv[nrsp] = rsp_id;
        nrsp++;
      end
      acc = req_valid & req_ready;
      tick();
      req_valid = req_valid & ~acc;
    end
    tests++;
    if (nrsp != 2) begin
      fails++;
      $display("FAIL cont_timeout: responses got %0d expected 2", nrsp);
    end
    tests++;
    if (q[0] !== 9'h002 || idv[0] !== 1'b0) begin
      fails++;
      $display("FAIL cont_first: Q=%h id=%b expected 002 0", q[0], idv[0]);
    end
    tests++;
    if (q[1] !== 9'h0FE || idv[1] !== 1'b1) begin
      fails++;
      $display("FAIL cont_second: Q=%h id=%b expected 0FE 1", q[1], idv[1]);
    end
  endtask

  task automatic test_fairness();
    logic       grants [6];
    logic       rid [6];
    logic [N:0] rq [6];
    logic [N:0] exp_q;
    int         ng;
    int         nr;
    logic       stop;
    ng = 0; nr = 0; stop = 1'b0;
    req_A[0] = 8'd10;  req_B[0] = 8'd20;  req_sel[0] = 3'b000;
    req_A[1] = 8'hAA;  req_B[1] = 8'h0F;  req_sel[1] = 3'b110;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 80 && nr < 6; c++) begin
      if (req_ready != 2'b00 && ng < 6) begin
        grants[ng] = req_ready[1];
        ng++;
        if (ng == 6) stop = 1'b1;
      end
      if (rsp_valid) begin
        rid[nr] = rsp_id;
        rq[nr]  = rsp_Q;
        nr++;
      end
      tick();
      if (stop) req_valid = 2'b00;
    end
    tests++;
    if (ng != 6 || nr != 6) begin
      fails++;
      $display("FAIL fair_timeout: grants=%0d responses=%0d expected 6 6", ng, nr);
    end
    for (int k = 0; k < 6; k++) begin
      if (k < ng && k < nr) begin
        exp_q = (k % 2 == 1) ? 9'h0A5 : 9'h01E;
        tests++;
        if (grants[k] !== 1'(k % 2) || rid[k] !== 1'(k % 2) || rq[k] !== exp_q) begin
          fails++;
          $display("FAIL fair_op%0d: grant=%b id=%b Q=%h expected %0d %0d %h",
                   k, grants[k], rid[k], rq[k], k % 2, k % 2, exp_q);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_A[0] = 8'd16; req_B[0] = 8'd17; req_sel[0] = 3'b010;
    req_valid = 2'b01;
    tick();
    req_A[1] = 8'd1; req_B[1] = 8'd1; req_sel[1] = 3'b000;
    req_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_Q !== 9'h010 || req_ready !== 2'b00 || rsp_id !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%b Q=%h ready=%b id=%b expected 1 010 00 0",
                 i, rsp_valid, rsp_Q, req_ready, rsp_id);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
      fails++;
      $display("FAIL bp_release: valid=%b ready=%b expected 0 10", rsp_valid, req_ready);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_nor_reset();
    req_A[1] = 8'h0C; req_B[1] = 8'h03; req_sel[1] = 3'b111;
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_Q !== 9'h0F0 || rsp_id !== 1'b1) begin
      fails++;
      $display("FAIL nor_result: valid=%b Q=%h id=%b expected 1 0F0 1", rsp_valid, rsp_Q, rsp_id);
    end
    tick();
    req_A[0] = 8'd1; req_B[0] = 8'd1; req_sel[0] = 3'b000;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || rsp_Q !== 9'h000 || rsp_id !== 1'b0 || rsp_err !== 1'b0 ||
        req_ready !== 2'b00) begin
      fails++;
      $display("FAIL midop_reset: valid=%b Q=%h id=%b err=%b ready=%b expected 0 000 0 0 00",
               rsp_valid, rsp_Q, rsp_id, rsp_err, req_ready);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || rsp_Q !== 9'h000) begin
      fails++;
      $display("FAIL midop_norsp: valid=%b Q=%h expected 0 000", rsp_valid, rsp_Q);
    end
  endtask

  task automatic test_div();
    rsp_ready = 1'b1;
`ifdef ALU_ARBITER_DIVZERO_EN
    req_A[0] = 8'd9; req_B[0] = 8'd0; req_sel[0] = 3'b011;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_Q !== 9'h000 || rsp_err !== 1'b1) begin
      fails++;
      $display("FAIL divzero: valid=%b Q=%h err=%b expected 1 000 1", rsp_valid, rsp_Q, rsp_err);
    end
    tick();
`endif
    req_A[0] = 8'd9; req_B[0] = 8'd2; req_sel[0] = 3'b011;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_Q !== 9'h004 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL div: valid=%b Q=%h err=%b expected 1 004 0", rsp_valid, rsp_Q, rsp_err);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_contention();
    test_fairness();
    test_backpressure();
    test_nor_reset();
    test_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
